// File: rtl/axi2apb_ctrl.sv
// AXI-to-APB bridge controller: takes one command at a time from an external AXI command FIFO,
// runs a single APB transfer on one of 16 slaves and returns a held B or R response.
module axi2apb_ctrl #(
  parameter int AXI_ID_WIDTH   = 6,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_TIMEOUT    = 256
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      cmd_empty,
  input  logic                      cmd_read,
  input  logic [AXI_ID_WIDTH-1:0]   cmd_id,
  input  logic [APB_ADDR_WIDTH+3:0] cmd_addr,
  input  logic                      cmd_err,
  output logic                      finish_wr,
  output logic                      finish_rd,
  input  logic [31:0]               WDATA,
  input  logic                      WLAST,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [AXI_ID_WIDTH-1:0]   BID,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  output logic [AXI_ID_WIDTH-1:0]   RID,
  output logic [31:0]               RDATA,
  output logic [1:0]                RRESP,
  output logic                      RLAST,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic [15:0]               PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int AW = APB_ADDR_WIDTH + 4;
  localparam int CW = $clog2(APB_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                    state, state_nxt;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_nxt;
  logic [AW-1:0]             addr_q, addr_nxt;
  logic                      read_q, read_nxt;
  logic                      err_q, err_nxt;
  logic                      hold_q, hold_nxt;
  logic [CW-1:0]             tcnt_q, tcnt_nxt;

  logic [15:0]               psel_nxt;
  logic                      penable_nxt;
  logic                      pwrite_nxt;
  logic [APB_ADDR_WIDTH-1:0] paddr_nxt;
  logic [31:0]               pwdata_nxt;
  logic                      wready_nxt;
  logic                      bvalid_nxt;
  logic [AXI_ID_WIDTH-1:0]   bid_nxt;
  logic [1:0]                bresp_nxt;
  logic                      rvalid_nxt;
  logic [AXI_ID_WIDTH-1:0]   rid_nxt;
  logic [31:0]               rdata_nxt;
  logic [1:0]                rresp_nxt;
  logic                      rlast_nxt;

  logic                      apb_tmo;
  logic [1:0]                apb_resp;

  function automatic logic [15:0] slave_sel(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

  assign apb_tmo   = (tcnt_q == CW'(APB_TIMEOUT - 1));
  assign finish_wr = BVALID & BREADY;
  assign finish_rd = RVALID & RREADY;

  always_comb begin
    state_nxt   = state;
    id_nxt      = id_q;
    addr_nxt    = addr_q;
    read_nxt    = read_q;
    err_nxt     = err_q;
    hold_nxt    = hold_q;
    tcnt_nxt    = tcnt_q;
    psel_nxt    = PSEL;
    penable_nxt = PENABLE;
    pwrite_nxt  = PWRITE;
    paddr_nxt   = PADDR;
    pwdata_nxt  = PWDATA;
    wready_nxt  = WREADY;
    bvalid_nxt  = BVALID;
    bid_nxt     = BID;
    bresp_nxt   = BRESP;
    rvalid_nxt  = RVALID;
    rid_nxt     = RID;
    rdata_nxt   = RDATA;
    rresp_nxt   = RRESP;
    rlast_nxt   = RLAST;
    apb_resp    = 2'b00;

    case (state)
      S_IDLE: begin
        // The FIFO head is being replaced on the edge that pops it; skip one cycle before sampling.
        hold_nxt = 1'b0;
        if (!hold_q && !cmd_empty) begin
          id_nxt   = cmd_id;
          addr_nxt = cmd_addr;
          read_nxt = cmd_read;
          err_nxt  = cmd_err;
          if (!cmd_read) begin
            state_nxt  = S_WDATA;
            wready_nxt = 1'b1;
          end else if (!cmd_err) begin
            state_nxt  = S_SETUP;
            psel_nxt   = slave_sel(cmd_addr[AW-1:APB_ADDR_WIDTH]);
            paddr_nxt  = cmd_addr[APB_ADDR_WIDTH-1:0];
            pwrite_nxt = 1'b0;
          end else begin
            state_nxt  = S_RESP;
            rvalid_nxt = 1'b1;
            rlast_nxt  = 1'b1;
            rid_nxt    = cmd_id;
            rdata_nxt  = 32'h0;
            rresp_nxt  = 2'b10;
          end
        end
      end

      S_WDATA: begin
        if (WVALID) begin
          pwdata_nxt = WDATA;
          if (!err_q) begin
            state_nxt  = S_SETUP;
            wready_nxt = 1'b0;
            psel_nxt   = slave_sel(addr_q[AW-1:APB_ADDR_WIDTH]);
            paddr_nxt  = addr_q[APB_ADDR_WIDTH-1:0];
            pwrite_nxt = 1'b1;
          end else if (WLAST) begin
            // Unsupported burst: swallow every beat, answer once, never touch APB.
            state_nxt  = S_RESP;
            wready_nxt = 1'b0;
            bvalid_nxt = 1'b1;
            bid_nxt    = id_q;
            bresp_nxt  = 2'b10;
          end
        end
      end

      S_SETUP: begin
        state_nxt   = S_ACCESS;
        penable_nxt = 1'b1;
        tcnt_nxt    = '0;
      end

      S_ACCESS: begin
        if (PREADY || apb_tmo) begin
          state_nxt   = S_RESP;
          psel_nxt    = 16'h0;
          penable_nxt = 1'b0;
          apb_resp    = (!PREADY || PSLVERR) ? 2'b10 : 2'b00;
          if (read_q) begin
            rvalid_nxt = 1'b1;
            rlast_nxt  = 1'b1;
            rid_nxt    = id_q;
            rdata_nxt  = PREADY ? PRDATA : 32'h0;
            rresp_nxt  = apb_resp;
          end else begin
            bvalid_nxt = 1'b1;
            bid_nxt    = id_q;
            bresp_nxt  = apb_resp;
          end
        end else begin
          tcnt_nxt = tcnt_q + CW'(1);
        end
      end

      S_RESP: begin
        if (BVALID && BREADY) begin
          state_nxt  = S_IDLE;
          bvalid_nxt = 1'b0;
          hold_nxt   = 1'b1;
        end else if (RVALID && RREADY) begin
          state_nxt  = S_IDLE;
          rvalid_nxt = 1'b0;
          rlast_nxt  = 1'b0;
          hold_nxt   = 1'b1;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
      tcnt_q  <= '0;
      PSEL    <= 16'h0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= 32'h0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= 2'b00;
      RVALID  <= 1'b0;
      RID     <= '0;
      RDATA   <= 32'h0;
      RRESP   <= 2'b00;
      RLAST   <= 1'b0;
    end else begin
      state   <= state_nxt;
      id_q    <= id_nxt;
      addr_q  <= addr_nxt;
      read_q  <= read_nxt;
      err_q   <= err_nxt;
      hold_q  <= hold_nxt;
      tcnt_q  <= tcnt_nxt;
      PSEL    <= psel_nxt;
      PENABLE <= penable_nxt;
      PWRITE  <= pwrite_nxt;
      PADDR   <= paddr_nxt;
      PWDATA  <= pwdata_nxt;
      WREADY  <= wready_nxt;
      BVALID  <= bvalid_nxt;
      BID     <= bid_nxt;
      BRESP   <= bresp_nxt;
      RVALID  <= rvalid_nxt;
      RID     <= rid_nxt;
      RDATA   <= rdata_nxt;
      RRESP   <= rresp_nxt;
      RLAST   <= rlast_nxt;
    end
  end

endmodule

// File: tb/tb_axi2apb_ctrl.sv
// Bench for axi2apb_ctrl: directed and randomized commands checked against a per-command
// outcome model (select, address, response code, data, access length, latency, beat count).
module tb_axi2apb_ctrl;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_empty, cmd_read, cmd_err;
  logic [5:0]  cmd_id;
  logic [15:0] cmd_addr;
  logic        finish_wr, finish_rd;
  logic [31:0] WDATA;
  logic        WLAST, WVALID, WREADY;
  logic [5:0]  BID, RID;
  logic [1:0]  BRESP, RRESP;
  logic        BVALID, BREADY, RLAST, RVALID, RREADY;
  logic [31:0] RDATA;
  logic [15:0] PSEL;
  logic        PENABLE, PWRITE;
  logic [11:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  int tests = 0;
  int fails = 0;

  axi2apb_ctrl #(.AXI_ID_WIDTH(6), .APB_ADDR_WIDTH(12), .APB_TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_empty(cmd_empty), .cmd_read(cmd_read), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_err(cmd_err), .finish_wr(finish_wr), .finish_rd(finish_rd),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_apb"}, {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 64'h0);
    chk({tag, "_axi"}, {WREADY, BVALID, BID, BRESP, RVALID, RID, RDATA, RRESP, RLAST,
                        finish_wr, finish_rd}, 64'h0);
  endtask

  // One command through the bridge. waits = PREADY-low cycles in ACCESS before ready;
  // rdy_delay = response-valid cycles before BREADY/RREADY; rst_at = ACCESS cycle to pulse reset (-1 none).
  task automatic run_cmd(input bit rd, input logic [5:0] id, input logic [15:0] addr, input bit err,
                         input logic [31:0] wd, input int nbeats, input int waits, input bit slverr,
                         input logic [31:0] prd, input int rdy_delay, input int rst_at_in);
    bit          tmo;
    int          exp_acc, exp_lat, exp_beats, exp_psel_cyc;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic [15:0] exp_psel;
    int          cyc, acc, psel_cyc, beats, fin_wr, fin_rd, vcnt, rst_at;
    bit          hs_w, vseen, psel_first, done;

    tmo          = !err && (waits >= TMO);
    exp_acc      = err ? 0 : (tmo ? TMO : waits + 1);
    exp_psel_cyc = err ? 0 : exp_acc + 1;
    exp_resp     = (err || tmo || slverr) ? 2'b10 : 2'b00;
    exp_rdata    = (err || tmo) ? 32'h0 : prd;
    exp_psel     = err ? 16'h0 : (16'h0001 << addr[15:12]);
    exp_beats    = rd ? 0 : (err ? nbeats : 1);
    if (err) exp_lat = rd ? 1 : 1 + nbeats;
    else     exp_lat = (rd ? 2 : 3) + exp_acc;

    cyc = 0; acc = 0; psel_cyc = 0; beats = 0; fin_wr = 0; fin_rd = 0; vcnt = 0;
    hs_w = 0; vseen = 0; psel_first = 1; done = 0; rst_at = rst_at_in;

    cmd_read = rd; cmd_id = id; cmd_addr = addr; cmd_err = err; cmd_empty = 1'b0;
    PRDATA = prd; PSLVERR = slverr; PREADY = 1'b0; BREADY = 1'b0; RREADY = 1'b0;
    WVALID = !rd; WDATA = wd; WLAST = (nbeats == 1);

    while (!done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (hs_w) begin
        beats++;
        if (!err || beats >= nbeats) begin
          WVALID = 1'b0; WLAST = 1'b0;
        end else begin
          WDATA = wd + beats; WLAST = (beats == nbeats - 1);
        end
      end
      chk("psel_onehot", $onehot0(PSEL), 1);
      if (PENABLE) chk("penable_needs_psel", PSEL != 16'h0, 1);
      if (PSEL != 16'h0) begin
        psel_cyc++;
        chk("psel", PSEL, exp_psel);
        chk("paddr", PADDR, addr[11:0]);
        chk("pwrite", PWRITE, !rd);
        if (!rd) chk("pwdata", PWDATA, wd);
        if (psel_first) chk("setup_penable", PENABLE, 0);
        psel_first = 0;
      end
      if (PENABLE) acc++;
      if (PENABLE && acc == rst_at) begin
        rstn = 1'b0; PREADY = 1'b0;
        #1 chk_all_zero("reset_mid_access");
        @(posedge clk); #1;
        rstn = 1'b1;
        cyc = 0; acc = 0; psel_cyc = 0; psel_first = 1; hs_w = 0; rst_at = -1;
        continue;
      end
      PREADY = PENABLE && (acc == waits + 1);
      if (BVALID || RVALID) begin
        chk("resp_channel", {BVALID, RVALID}, rd ? 2'b01 : 2'b10);
        if (!vseen) chk("latency", cyc, exp_lat);
        vseen = 1;
        if (rd) begin
          chk("rid", RID, id); chk("rresp", RRESP, exp_resp);
          chk("rdata", RDATA, exp_rdata); chk("rlast", RLAST, 1);
        end else begin
          chk("bid", BID, id); chk("bresp", BRESP, exp_resp);
        end
        BREADY = !rd && (vcnt >= rdy_delay);
        RREADY = rd && (vcnt >= rdy_delay);
        vcnt++;
      end
      #1;
      hs_w = WVALID && WREADY;
      if (finish_wr) begin fin_wr++; chk("finish_wr_hs", {BVALID, BREADY}, 2'b11); end
      if (finish_rd) begin fin_rd++; chk("finish_rd_hs", {RVALID, RREADY}, 2'b11); end
      if (fin_wr + fin_rd > 0) done = 1;
    end
    chk("cmd_completed", done, 1);
    if (!rd && !err && hs_w) beats++;
    else if (err && hs_w) beats++;

    @(posedge clk); #1;
    cmd_empty = 1'b1; BREADY = 1'b0; RREADY = 1'b0; PREADY = 1'b0; WVALID = 1'b0; WLAST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("valid_dropped", {BVALID, RVALID, PSEL}, 0);
      #1 chk("no_extra_finish", {finish_wr, finish_rd}, 0);
      @(posedge clk); #1;
    end
    chk("w_beats", beats, exp_beats);
    chk("access_cycles", acc, exp_acc);
    chk("psel_cycles", psel_cyc, exp_psel_cyc);
    chk("finish_counts", {fin_wr[7:0], fin_rd[7:0]}, {8'(!rd), 8'(rd)});
  endtask

  initial begin
    bit          rd, err, sl;
    int          w, r, nb;
    logic [15:0] ad;

    rstn = 1'b0; cmd_empty = 1'b1; cmd_read = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_err = 1'b0;
    WDATA = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0; RREADY = 1'b0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset_state");
    rstn = 1'b1;
    @(posedge clk); #1;

    // Basic write, zero-wait
    run_cmd(0, 6'h05, 16'h3010, 0, 32'hDEADBEEF, 1, 0, 0, 32'h0, 0, -1);
    // Read to slave 15 with three wait states
    run_cmd(1, 6'h2A, 16'hFFFC, 0, 32'h0, 0, 3, 0, 32'h12345678, 0, -1);
    // Unsupported 4-beat write: drained, error response, no APB
    run_cmd(0, 6'h11, 16'h5000, 1, 32'h000000A0, 4, 0, 0, 32'h0, 1, -1);
    // Read with PREADY stuck low: timeout
    run_cmd(1, 6'h3F, 16'h2004, 0, 32'h0, 0, 10000, 0, 32'hCAFEF00D, 0, -1);
    // PREADY arriving on the last allowed ACCESS cycle is not a timeout
    run_cmd(1, 6'h02, 16'h6008, 0, 32'h0, 0, TMO - 1, 0, 32'hA5A5A5A5, 0, -1);
    // Slave error on write with BREADY held off for 5 cycles
    run_cmd(0, 6'h07, 16'h7100, 0, 32'h0BADF00D, 1, 1, 1, 32'h0, 5, -1);
    // Unsupported read: immediate single error beat
    run_cmd(1, 6'h01, 16'h1000, 1, 32'h0, 0, 0, 0, 32'hFFFFFFFF, 2, -1);
    // Reset in ACCESS: abandoned, then the still-queued command runs
    run_cmd(1, 6'h15, 16'hA040, 0, 32'h0, 0, 5, 0, 32'h55AA55AA, 2, 3);

    for (int n = 0; n < 40; n++) begin
      rd  = 1'($urandom_range(0, 1));
      err = ($urandom_range(0, 4) == 0);
      sl  = 1'($urandom_range(0, 1));
      ad  = 16'($urandom_range(0, 16'hFFFF));
      r   = $urandom_range(0, 7);
      if (r == 0)      w = TMO - 1;
      else if (r == 1) w = TMO;
      else             w = $urandom_range(0, 3);
      nb = rd ? 0 : (err ? $urandom_range(1, 4) : 1);
      run_cmd(rd, 6'($urandom_range(0, 63)), ad, err, $urandom, nb, w, sl, $urandom,
              $urandom_range(0, 3), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi2apb_ctrl.md
AXI2APB_CTRL -- requirements
Module: axi2apb_ctrl

Interface
REQ-001 SHALL have parameter AXI_ID_WIDTH, default 6, AXI ID width.
REQ-002 SHALL have parameter APB_ADDR_WIDTH, default 12, per-slave APB address width (4KB slaves).
REQ-003 SHALL have parameter APB_TIMEOUT, default 256, cycles allowed in ACCESS before forced error.
REQ-004 Port list:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- cmd_empty  in  1  command FIFO empty
- cmd_read  in  1  head command is a read (1) or write (0)
- cmd_id  in  AXI_ID_WIDTH  head command ID
- cmd_addr  in  APB_ADDR_WIDTH+4  head address; top 4 bits = slave index
- cmd_err  in  1  head command unsupported (size/len)
- finish_wr  out  1  pop strobe, write command complete
- finish_rd  out  1  pop strobe, read command complete
- WDATA  in  32  write data
- WLAST  in  1  last write beat
- WVALID  in  1  write data valid
- WREADY  out  1  write data accept
- BID  out  AXI_ID_WIDTH  write response ID
- BRESP  out  2  write response
- BVALID  out  1  write response valid
- BREADY  in  1  write response accept
- RID  out  AXI_ID_WIDTH  read ID
- RDATA  out  32  read data
- RRESP  out  2  read response
- RLAST  out  1  last read beat
- RVALID  out  1  read valid
- RREADY  in  1  read accept
- PSEL  out  16  one-hot APB slave select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  APB_ADDR_WIDTH  APB address
- PWDATA  out  32  APB write data
- PRDATA  in  32  APB read data (muxed externally)
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error
REQ-005 Clock is clk; reset is rstn, asynchronous, active-low.

Function
REQ-006 SHALL implement FSM states IDLE, WDATA, SETUP, ACCESS, RESP; one command in flight.
REQ-007 IDLE: cmd_empty=0 -> latch cmd_id/cmd_addr/cmd_read/cmd_err; write -> WDATA; read with cmd_err=0 -> SETUP; read with cmd_err=1 -> RESP.
REQ-008 WDATA: WREADY=1 (registered, asserted on state entry); each WVALID&WREADY beat captures WDATA into PWDATA.
REQ-009 WDATA, cmd_err=0: first beat -> SETUP; cmd_err=1: beats drained until WVALID&WLAST -> RESP, no APB access.
REQ-010 SETUP: PSEL[cmd_addr[APB_ADDR_WIDTH+3:APB_ADDR_WIDTH]]=1, PENABLE=0, PADDR=cmd_addr[APB_ADDR_WIDTH-1:0], PWRITE=~cmd_read; exactly one cycle -> ACCESS.
REQ-011 ACCESS: PENABLE=1, PSEL/PADDR/PWRITE/PWDATA held stable until exit.
REQ-012 ACCESS exit on PREADY=1: capture PRDATA and PSLVERR; PSEL, PENABLE cleared next cycle; -> RESP.
REQ-013 ACCESS timeout: wait counter reset on SETUP; at APB_TIMEOUT cycles in ACCESS without PREADY, exit as if PSLVERR=1, RDATA=0.
REQ-014 RESP write: BVALID=1, BID=latched id, BRESP=2'b10 if cmd_err|PSLVERR|timeout else 2'b00; held until BREADY.
REQ-015 RESP read: RVALID=1, RLAST=1, RID=latched id, RDATA=captured data (0 on cmd_err), RRESP as REQ-014.
REQ-016 Error commands SHALL yield exactly one R beat / one B response regardless of original burst length.
REQ-017 finish_wr = BVALID&BREADY, finish_rd = RVALID&RREADY, combinational, one-cycle pulse per command; FSM -> IDLE same edge.
REQ-018 IDLE SHALL not resample FIFO head in the cycle of a finish pulse (FIFO head updates that edge; next command earliest one cycle after return to IDLE).
REQ-019 BVALID/RVALID, once high, SHALL not drop or change payload until handshake.
REQ-020 Minimum write latency AW-in-FIFO to BVALID: 4 cycles (IDLE, WDATA, SETUP, ACCESS with PREADY=1); read: 3 cycles.
REQ-021 Only one PSEL bit high at any time; PENABLE=1 only when PSEL nonzero.

Reset
REQ-022 rstn low SHALL asynchronously force IDLE and clear PSEL, PENABLE, PWRITE, PADDR, PWDATA, WREADY, BVALID, BID, BRESP, RVALID, RID, RDATA, RRESP, RLAST, timeout counter, latched command.
REQ-023 finish_wr/finish_rd SHALL be 0 during reset; reset mid-transfer abandons it with no response and no pop.

Verification
REQ-024 Write cmd_addr=0x3_010, WDATA=0xDEADBEEF, PREADY=1 -> PSEL=16'h0008, PADDR=0x010, PWDATA=0xDEADBEEF, BRESP=00, one finish_wr pulse.
REQ-025 Read cmd_addr=0xF_FFC, PRDATA=0x12345678, PREADY after 3 wait cycles -> PSEL=16'h8000, RDATA=0x12345678, RLAST=1, RRESP=00, one finish_rd.
REQ-026 Write with cmd_err=1, 4 W beats -> WREADY accepts all 4, no PSEL, BRESP=10 after WLAST beat.
REQ-027 Read, PREADY stuck 0 -> PENABLE high exactly APB_TIMEOUT cycles, RRESP=10, RDATA=0.
REQ-028 PSLVERR=1 on write, BREADY held 0 for 5 cycles -> BVALID/BID/BRESP=10 stable, finish_wr only on BREADY cycle.
REQ-029 rstn low during ACCESS -> all outputs 0 immediately, no finish pulse, next queued command runs normally after release.
